// File: rtl/ahb_bus_arbiter.sv
// Round-robin arbiter for the shared AHB master port: grants one requester at a time,
// steers its address/control/data onto the shared bus, and reclaims a stuck grant by watchdog.
module ahb_bus_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                 m_clock,
    input  logic                 p_reset_n,
    input  logic [NREQ-1:0]      bus_req,
    input  logic [NREQ-1:0]      bus_open,
    output logic [NREQ-1:0]      bus_grant,
    input  logic [NREQ*32-1:0]   m_haddr,
    input  logic [NREQ*32-1:0]   m_hwdata,
    input  logic [NREQ*3-1:0]    m_hburst,
    input  logic [NREQ*2-1:0]    m_hsize,
    input  logic [NREQ*2-1:0]    m_htrans,
    input  logic [NREQ-1:0]      m_hwrite,
    output logic [31:0]          HADDR,
    output logic [31:0]          HWDATA,
    output logic [2:0]           HBURST,
    output logic [1:0]           HSIZE,
    output logic [1:0]           HTRANS,
    output logic                 HWRITE,
    output logic [2:0]           owner,
    output logic                 busy,
    output logic                 timeout_err,
    output logic [2:0]           err_id
);

    localparam int              WDW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WDW-1:0]  WD_LAST   = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [2:0]      LAST_INIT = 3'(NREQ - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state, state_nxt;
    logic [NREQ-1:0]  pend, pend_nxt, grant_nxt, req_all, win_onehot;
    logic [2:0]       owner_nxt, last_owner, last_owner_nxt, err_id_nxt, winner;
    logic             win_found, open_hit, wd_expire, terr_nxt;
    logic [WDW-1:0]   wdog, wdog_nxt;
    int               rr_best, rr_dist;

    assign req_all   = pend | bus_req;
    assign win_found = |req_all;
    assign busy      = (state == GRANT);
    // Only the owner's open can hit, since bus_grant is one-hot on the owner while busy.
    assign open_hit  = |(bus_open & bus_grant);
    assign wd_expire = (TIMEOUT != 0) && (wdog == WD_LAST);

    // Round-robin pick: the requester closest after last_owner (cyclically) wins.
    always_comb begin
        winner     = '0;
        rr_best    = NREQ;
        rr_dist    = 0;
        win_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            rr_dist = (i + NREQ - 1 - int'(last_owner)) % NREQ;
            if (req_all[i] && (rr_dist < rr_best)) begin
                rr_best = rr_dist;
                winner  = 3'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            win_onehot[i] = win_found && (winner == 3'(i));
        end
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = bus_grant;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        pend_nxt       = req_all;
        wdog_nxt       = wdog;
        terr_nxt       = 1'b0;
        err_id_nxt     = err_id;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt      = GRANT;
                    grant_nxt      = win_onehot;
                    owner_nxt      = winner;
                    last_owner_nxt = winner;
                    pend_nxt       = req_all & ~win_onehot;
                    wdog_nxt       = '0;
                end
            end
            GRANT: begin
                if (open_hit) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                end else if (wd_expire) begin
                    state_nxt  = IDLE;
                    grant_nxt  = '0;
                    terr_nxt   = 1'b1;
                    err_id_nxt = owner;
                end else if (wdog != '1) begin
                    wdog_nxt = wdog + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge m_clock or negedge p_reset_n) begin
        if (!p_reset_n) begin
            state       <= IDLE;
            bus_grant   <= '0;
            owner       <= '0;
            last_owner  <= LAST_INIT;
            pend        <= '0;
            wdog        <= '0;
            timeout_err <= 1'b0;
            err_id      <= '0;
        end else begin
            state       <= state_nxt;
            bus_grant   <= grant_nxt;
            owner       <= owner_nxt;
            last_owner  <= last_owner_nxt;
            pend        <= pend_nxt;
            wdog        <= wdog_nxt;
            timeout_err <= terr_nxt;
            err_id      <= err_id_nxt;
        end
    end

    // Shared bus is parked at zero (HTRANS=IDLE) whenever nobody holds the grant.
    always_comb begin
        HADDR  = '0;
        HWDATA = '0;
        HBURST = '0;
        HSIZE  = '0;
        HTRANS = '0;
        HWRITE = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (busy && (owner == 3'(i))) begin
                HADDR  = m_haddr[i*32 +: 32];
                HWDATA = m_hwdata[i*32 +: 32];
                HBURST = m_hburst[i*3 +: 3];
                HSIZE  = m_hsize[i*2 +: 2];
                HTRANS = m_htrans[i*2 +: 2];
                HWRITE = m_hwrite[i];
            end
        end
    end

endmodule
